// File: rtl/serial_probe_master.sv
//------------------------------------------------------------------------------
// serial_probe_master
//
// Purpose:
//    Host-side driver for a cs/i/o serial shift target. A start request sends a
//    CMD_BITS command word LSB first while chip-select is low. It then raises
//    chip-select for one serial clock so the target can latch and compare. It
//    finally clocks RESP_BITS response bits back LSB first and presents them
//    as one parallel word. This block generates the target's clock, select
//    and data.
//
// Ports:
//    i_clk       system clock, all logic on the rising edge
//    i_rst       synchronous active-high reset
//    i_start     transaction request, honoured only while idle
//    i_txWord    command word, captured on the cycle start is accepted
//    o_busy      transaction in progress
//    o_done      one-cycle pulse, o_rxData valid from this cycle
//    o_rxData    received response, held until the next accepted start
//    o_spiClk    serial clock to the target (idles low)
//    o_spiCs     chip select to the target, active low (idles high)
//    o_spiMosi   serial data to the target
//    i_spiMiso   serial data from the target
//------------------------------------------------------------------------------
module serial_probe_master #(
   parameter int CMD_BITS  = 32,
   parameter int RESP_BITS = 256,
   parameter int CLK_DIV   = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic [CMD_BITS-1:0]  i_txWord,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [RESP_BITS-1:0] o_rxData,
   output logic                 o_spiClk,
   output logic                 o_spiCs,
   output logic                 o_spiMosi,
   input  logic                 i_spiMiso
);

   // The bit counter spans the longer of the two shift sequences; the divider
   // counter spans one half-period of the serial clock.
   localparam int MAX_BITS = (CMD_BITS > RESP_BITS) ? CMD_BITS : RESP_BITS;
   localparam int BIT_W    = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
   localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [BIT_W-1:0] CMD_LAST  = BIT_W'(CMD_BITS - 1);
   localparam logic [BIT_W-1:0] RESP_LAST = BIT_W'(RESP_BITS - 1);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      LATCH,
      READ
   } stateT;

   stateT                r_state;
   logic [DIV_W-1:0]     r_divCnt;
   logic [BIT_W-1:0]     r_bitCnt;
   logic [CMD_BITS-2:0]  r_txShift;
   logic                 r_busy;
   logic                 r_done;
   logic [RESP_BITS-1:0] r_rxData;
   logic                 r_spiClk;
   logic                 r_spiCs;
   logic                 r_spiMosi;

   logic                 w_phaseEnd;

   // A half-period of the serial clock is over when the divider reaches its
   // terminal count; every phase change of spi_clk happens on that edge.
   assign w_phaseEnd = (r_divCnt == DIV_LAST);

   // The whole transaction sequencer. Each bit slot is a low phase followed
   // by a high phase. The response bit is sampled on the edge that raises
   // spi_clk, before the target shifts on that same rising edge. Select and
   // data only move on the edge that starts a new low phase, so they are
   // settled long before the target's next rising edge. r_txShift holds the
   // command bits still to be sent; the bit currently on the line already
   // sits in r_spiMosi. The response is shifted in from the top so that the
   // first bit received ends up in bit 0 after the last slot. A start
   // request is refused during the done cycle; it is taken from the
   // following cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= IDLE;
         r_divCnt  <= '0;
         r_bitCnt  <= '0;
         r_txShift <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_rxData  <= '0;
         r_spiClk  <= 1'b0;
         r_spiCs   <= 1'b1;
         r_spiMosi <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == IDLE) begin
            if (i_start && !r_done) begin
               r_state   <= SEND;
               r_busy    <= 1'b1;
               r_divCnt  <= '0;
               r_bitCnt  <= '0;
               r_spiClk  <= 1'b0;
               r_spiCs   <= 1'b0;
               r_spiMosi <= i_txWord[0];
               r_txShift <= i_txWord[CMD_BITS-1:1];
            end
         end else if (!w_phaseEnd) begin
            r_divCnt <= r_divCnt + 1'b1;
         end else begin
            r_divCnt <= '0;
            if (!r_spiClk) begin
               r_spiClk <= 1'b1;
               if (r_state == READ) begin
                  r_rxData <= {i_spiMiso, r_rxData[RESP_BITS-1:1]};
               end
            end else begin
               r_spiClk <= 1'b0;
               case (r_state)
                  SEND: begin
                     if (r_bitCnt == CMD_LAST) begin
                        r_state   <= LATCH;
                        r_bitCnt  <= '0;
                        r_spiCs   <= 1'b1;
                        r_spiMosi <= 1'b0;
                     end else begin
                        r_bitCnt  <= r_bitCnt + 1'b1;
                        r_spiMosi <= r_txShift[0];
                        r_txShift <= r_txShift >> 1;
                     end
                  end
                  LATCH: begin
                     r_state <= READ;
                     r_spiCs <= 1'b0;
                  end
                  READ: begin
                     if (r_bitCnt == RESP_LAST) begin
                        r_state  <= IDLE;
                        r_bitCnt <= '0;
                        r_spiCs  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                     end else begin
                        r_bitCnt <= r_bitCnt + 1'b1;
                     end
                  end
                  default: begin
                     r_state <= IDLE;
                  end
               endcase
            end
         end
      end
   end

   // Every output comes straight from a register.
   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_rxData  = r_rxData;
   assign o_spiClk  = r_spiClk;
   assign o_spiCs   = r_spiCs;
   assign o_spiMosi = r_spiMosi;

endmodule
